// File: rtl/fifo_buffer.sv
// Single-clock first-word-fall-through FIFO with a sticky overflow flag.
// The head word is driven from registered state only, so data_out never follows read/write.
module fifo_buffer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             read,
  input  logic             write,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             ready,
  output logic             overflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic empty, full, do_read, do_write;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign do_read  = read && !empty;
  // A write into a full FIFO is only accepted when a pop frees the head slot in the same edge.
  assign do_write = write && (!full || do_read);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    // DEPTH is a power of two, so pointer wrap is the natural AW-bit rollover.
    if (do_write) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_read)  rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({do_write, do_read})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (write && full && !read) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr_q] <= data_in;
  end

  assign data_out = mem[rd_ptr_q];
  assign ready    = !empty;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fifo_buffer.sv
// Directed bench for fifo_buffer: popped words are checked by a negedge monitor against
// an expectation queue filled by the stimulus; flags and head words are checked directly.
module tb_fifo_buffer;

  logic       clk = 1'b0;
  logic       clr;
  logic       read;
  logic       write;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       ready;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  logic       ovf_m;

  fifo_buffer #(
    .WIDTH(8),
    .DEPTH(8)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .read    (read),
    .write   (write),
    .data_in (data_in),
    .data_out(data_out),
    .ready   (ready),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Consumer side: a pop happens at the coming edge when read && ready.
  always @(negedge clk) begin
    if (!clr && read && ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %02h expected no pop at %0t", data_out, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          errors++;
          $display("FAIL pop_data: got %02h expected %02h at %0t", data_out, e, $time);
        end
      end
    end
  end

  // One clock of stimulus; expectation queue is loaded before the edge.
  task automatic cycle(input logic r, input logic w, input logic [7:0] d);
    logic rd_ok;
    logic wr_ok;
    int   pre;
    pre   = model_q.size();
    rd_ok = r && (pre != 0);
    wr_ok = w && ((pre < 8) || rd_ok);
    if (w && (pre == 8) && !r) ovf_m = 1'b1;
    if (rd_ok) exp_q.push_back(model_q.pop_front());
    if (wr_ok) model_q.push_back(d);
    read    = r;
    write   = w;
    data_in = d;
    @(posedge clk);
    #1;
    read  = 1'b0;
    write = 1'b0;
    check("ready", {7'd0, ready}, {7'd0, model_q.size() != 0});
    check("overflow", {7'd0, overflow}, {7'd0, ovf_m});
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    clr = 1'b1;
    read = 1'b0;
    write = 1'b0;
    model_q.delete();
    exp_q.delete();
    ovf_m = 1'b0;
    #1;
    check("reset_ready", {7'd0, ready}, 8'd0);
    check("reset_overflow", {7'd0, overflow}, 8'd0);
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    clr     = 1'b1;
    read    = 1'b0;
    write   = 1'b0;
    data_in = 8'h00;
    ovf_m   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("init_ready", {7'd0, ready}, 8'd0);
    check("init_overflow", {7'd0, overflow}, 8'd0);
    clr = 1'b0;

    // Reset mid-stream with five words held.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'hA0 + 8'(i));
    check("pre_reset_ready", {7'd0, ready}, 8'd1);
    do_reset();

    // Fill with six words.
    cycle(1'b0, 1'b1, 8'hE0);
    check("fill_first_ready", {7'd0, ready}, 8'd1);
    check("fill_first_head", data_out, 8'hE0);
    for (int i = 1; i < 6; i++) cycle(1'b0, 1'b1, 8'hE0 + 8'(i));
    check("fill_head", data_out, 8'hE0);
    check("fill_overflow", {7'd0, overflow}, 8'd0);

    // Concurrent read+write keeps six entries while the head advances.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 8'hE6 + 8'(i));
      check("rw_head", data_out, 8'hE1 + 8'(i));
    end

    // Overflow: two writes fill, the remaining six are dropped.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 8'hE9 + 8'(i));
      check("ovf_flag", {7'd0, overflow}, (i >= 2) ? 8'd1 : 8'd0);
    end
    check("full_head", data_out, 8'hE3);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'h00);
    check("drained_ready", {7'd0, ready}, 8'd0);
    check("sticky_overflow", {7'd0, overflow}, 8'd1);
    do_reset();

    // Wrap-around: 20 words with reads on three of every four cycles.
    for (int k = 0; k < 20; k++) cycle((k % 4) != 0, 1'b1, 8'(k));
    while (model_q.size() != 0) cycle(1'b1, 1'b0, 8'h00);
    check("wrap_overflow", {7'd0, overflow}, 8'd0);

    // Empty read is ignored; read+write on empty lands the word.
    cycle(1'b1, 1'b0, 8'h00);
    check("empty_read_ready", {7'd0, ready}, 8'd0);
    check("empty_read_overflow", {7'd0, overflow}, 8'd0);
    cycle(1'b1, 1'b1, 8'h55);
    check("rw_empty_ready", {7'd0, ready}, 8'd1);
    check("rw_empty_head", data_out, 8'h55);
    cycle(1'b1, 1'b0, 8'h00);

    @(negedge clk);
    check("exp_queue_drained", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
